// File: rtl/an_mux_scan_controller_if.sv
// Bundles the scan controller's tester-control, analog-mux and ADC-channel signals.
// master: tester/ADC side; slave: the scan controller.
interface an_mux_scan_controller_if #(
    parameter int AN_MUX_WIDTH = 8
);
    logic                    start;
    logic                    abort;
    logic [AN_MUX_WIDTH-1:0] first_addr;
    logic [AN_MUX_WIDTH-1:0] last_addr;
    logic                    busy;
    logic                    done;
    logic                    timeout_err;
    logic                    an_mux_enable;
    logic [AN_MUX_WIDTH-1:0] an_mux_addr;
    logic                    sample_adc;
    logic                    adc_updated;
    logic [11:0]             adc_measurement;
    logic                    result_valid;
    logic [AN_MUX_WIDTH-1:0] result_addr;
    logic [11:0]             result_data;

    modport master (
        output start, abort, first_addr, last_addr, adc_updated, adc_measurement,
        input  busy, done, timeout_err, an_mux_enable, an_mux_addr, sample_adc,
               result_valid, result_addr, result_data
    );

    modport slave (
        input  start, abort, first_addr, last_addr, adc_updated, adc_measurement,
        output busy, done, timeout_err, an_mux_enable, an_mux_addr, sample_adc,
               result_valid, result_addr, result_data
    );
endinterface

// File: rtl/an_mux_scan_controller.sv
// Sweeps a contiguous (wrapping) range of analog-mux addresses: settle, trigger the ADC,
// wait for its update and emit one tagged 12-bit result per channel.
module an_mux_scan_controller #(
    parameter int AN_MUX_WIDTH   = 8,
    parameter int SETTLE_CYCLES  = 100,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    an_mux_scan_controller_if.slave bus
);
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_WAIT, S_STORE, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [AN_MUX_WIDTH-1:0] cur_q, cur_d;
    logic [AN_MUX_WIDTH-1:0] last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    terr_q, terr_d;
    logic                    en_q, en_d;
    logic                    samp_q, samp_d;
    logic                    rv_q, rv_d;
    logic [AN_MUX_WIDTH-1:0] addr_q, addr_d;
    logic [AN_MUX_WIDTH-1:0] raddr_q, raddr_d;
    logic [11:0]             rdata_q, rdata_d;
    logic                    advance;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        raddr_d = raddr_q;
        rdata_d = rdata_q;
        advance = 1'b0;
        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        cur_d   = bus.first_addr;
                        last_d  = bus.last_addr;
                        cnt_d   = SETTLE_LOAD;
                        terr_d  = 1'b0;
                        state_d = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == '0) state_d = S_SAMPLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                S_SAMPLE: begin
                    cnt_d   = TIMEOUT_LOAD;
                    state_d = S_WAIT;
                end
                // An update strobe seen during SAMPLE belongs to an earlier conversion, so only WAIT captures.
                S_WAIT: begin
                    if (bus.adc_updated) begin
                        rdata_d = bus.adc_measurement;
                        raddr_d = cur_q;
                        state_d = S_STORE;
                    end else if (cnt_q == '0) begin
                        terr_d  = 1'b1;
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_STORE: advance = 1'b1;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
            if (advance) begin
                if (cur_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    cur_d   = cur_q + 1'b1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = S_SETTLE;
                end
            end
        end

        // Outputs are decoded from the next state so they are all register outputs.
        busy_d = (state_d != S_IDLE);
        en_d   = (state_d inside {S_SETTLE, S_SAMPLE, S_WAIT, S_STORE});
        addr_d = en_d ? cur_d : addr_q;
        samp_d = (state_d == S_SAMPLE);
        rv_d   = (state_d == S_STORE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            en_q    <= 1'b0;
            samp_q  <= 1'b0;
            rv_q    <= 1'b0;
            addr_q  <= '0;
            raddr_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
            en_q    <= en_d;
            samp_q  <= samp_d;
            rv_q    <= rv_d;
            addr_q  <= addr_d;
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.timeout_err   = terr_q;
    assign bus.an_mux_enable = en_q;
    assign bus.an_mux_addr   = addr_q;
    assign bus.sample_adc    = samp_q;
    assign bus.result_valid  = rv_q;
    assign bus.result_addr   = raddr_q;
    assign bus.result_data   = rdata_q;
endmodule

// File: tb/tb_an_mux_scan_controller.sv
// Bench for an_mux_scan_controller: directed scenarios plus randomized scans against a channel-list model.
module tb_an_mux_scan_controller;
    localparam int W  = 8;
    localparam int SC = 4;
    localparam int TC = 16;

    logic clk = 1'b0;
    logic rst;

    an_mux_scan_controller_if #(.AN_MUX_WIDTH(W)) bus ();

    an_mux_scan_controller #(
        .AN_MUX_WIDTH(W), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ADC behaviour per address: reply delay in cycles after sample_adc (0 = never) and data.
    int          dly_tab [256];
    logic [11:0] dat_tab [256];
    bit          stale_en = 1'b0;

    // ADC responder
    int         pend = 0;
    logic [W-1:0] resp_addr = '0;
    initial begin
        bus.adc_updated     = 1'b0;
        bus.adc_measurement = '0;
        forever begin
            @(posedge clk); #1;
            bus.adc_updated = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.adc_updated     = 1'b1;
                    bus.adc_measurement = dat_tab[resp_addr];
                end
            end
            if (bus.sample_adc) begin
                resp_addr = bus.an_mux_addr;
                pend      = dly_tab[resp_addr];
                if (stale_en) begin
                    bus.adc_updated     = 1'b1;
                    bus.adc_measurement = 12'hBAD;
                end
            end
        end
    end

    // Output monitor
    logic [W-1:0] obs_addr[$];
    logic [11:0]  obs_data[$];
    int samp_cyc[$];
    int done_cnt = 0, samp_cnt = 0, stab_viol = 0, stable = 0, cyc = 0, terr_rise = -1;
    logic terr_prev = 1'b0;
    logic [W-1:0] prev_addr = '0;
    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (bus.result_valid) begin
                obs_addr.push_back(bus.result_addr);
                obs_data.push_back(bus.result_data);
            end
            if (bus.done) done_cnt++;
            if (bus.an_mux_enable && stable > 0 && bus.an_mux_addr == prev_addr) stable++;
            else stable = bus.an_mux_enable ? 1 : 0;
            prev_addr = bus.an_mux_addr;
            if (bus.sample_adc) begin
                samp_cnt++;
                samp_cyc.push_back(cyc);
                if (stable < SC + 1) stab_viol++;
            end
            if (bus.timeout_err && !terr_prev) terr_rise = cyc;
            terr_prev = bus.timeout_err;
        end
    end

    // Reference model: expected result list for a scan
    logic [W-1:0] exp_addr[$];
    logic [11:0]  exp_data[$];
    int  exp_n = 0;
    logic exp_terr = 1'b0;

    task automatic model(input logic [W-1:0] f, input logic [W-1:0] l);
        exp_addr.delete();
        exp_data.delete();
        exp_terr = 1'b0;
        exp_n = ((int'(l) - int'(f) + 256) % 256) + 1;
        for (int i = 0; i < exp_n; i++) begin
            int a;
            a = (int'(f) + i) % 256;
            if (dly_tab[a] >= 1 && dly_tab[a] <= TC) begin
                exp_addr.push_back(W'(a));
                exp_data.push_back(dat_tab[a]);
            end else begin
                exp_terr = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        obs_addr.delete();
        obs_data.delete();
        samp_cyc.delete();
        done_cnt  = 0;
        samp_cnt  = 0;
        stab_viol = 0;
        terr_rise = -1;
    endtask

    // Returns at the negedge of cycle 1 (start sampled at the edge ending cycle 0).
    task automatic start_scan(input logic [W-1:0] f, input logic [W-1:0] l);
        @(negedge clk);
        bus.first_addr = f;
        bus.last_addr  = l;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (bus.busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_idle"}, bus.busy, 0);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_nres"}, obs_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
            chk($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
        end
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_nsamp"}, samp_cnt, exp_n);
        chk({tag, "_settle"}, stab_viol, 0);
        chk({tag, "_terr"}, bus.timeout_err, exp_terr);
    endtask

    task automatic do_scan(input string tag, input logic [W-1:0] f, input logic [W-1:0] l);
        clear_mon();
        model(f, l);
        start_scan(f, l);
        wait_idle(tag, exp_n * (SC + TC + 6) + 20);
        tick(2);
        compare(tag);
    endtask

    task automatic single_chk(input string tag);
        dly_tab[5] = 2;
        dat_tab[5] = 12'hABC;
        clear_mon();
        start_scan(8'h05, 8'h05);
        chk({tag, "_c1_addr"}, bus.an_mux_addr, 8'h05);
        chk({tag, "_c1_en"}, bus.an_mux_enable, 1);
        chk({tag, "_c1_busy"}, bus.busy, 1);
        chk({tag, "_c1_samp"}, bus.sample_adc, 0);
        tick(4);
        chk({tag, "_c5_samp"}, bus.sample_adc, 1);
        tick(3);
        chk({tag, "_c8_rv"}, bus.result_valid, 1);
        chk({tag, "_c8_raddr"}, bus.result_addr, 8'h05);
        chk({tag, "_c8_rdata"}, bus.result_data, 12'hABC);
        tick(1);
        chk({tag, "_c9_done"}, bus.done, 1);
        chk({tag, "_c9_rv"}, bus.result_valid, 0);
        tick(1);
        chk({tag, "_c10_busy"}, bus.busy, 0);
        chk({tag, "_c10_done"}, bus.done, 0);
        chk({tag, "_c10_en"}, bus.an_mux_enable, 0);
        chk({tag, "_c10_addr_hold"}, bus.an_mux_addr, 8'h05);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_terr"}, bus.timeout_err, 0);
        chk({tag, "_en"}, bus.an_mux_enable, 0);
        chk({tag, "_addr"}, bus.an_mux_addr, 0);
        chk({tag, "_samp"}, bus.sample_adc, 0);
        chk({tag, "_rv"}, bus.result_valid, 0);
        chk({tag, "_raddr"}, bus.result_addr, 0);
        chk({tag, "_rdata"}, bus.result_data, 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.first_addr = '0;
        bus.last_addr  = '0;
        for (int i = 0; i < 256; i++) begin
            dly_tab[i] = 1;
            dat_tab[i] = 12'(i);
        end

        tick(3);
        chk_all_zero("reset");
        rst = 1'b0;
        tick(2);

        single_chk("single");
        tick(3);

        // Wrap-around range, data = address, short random reply delays
        for (int a = 0; a < 256; a++) dat_tab[a] = 12'(a);
        dly_tab[8'hFE] = $urandom_range(1, 3);
        dly_tab[8'hFF] = $urandom_range(1, 3);
        dly_tab[8'h00] = $urandom_range(1, 3);
        dly_tab[8'h01] = $urandom_range(1, 3);
        do_scan("wrap", 8'hFE, 8'h01);

        // Timeout on the middle channel
        dly_tab[1] = 2;
        dly_tab[2] = 0;
        dly_tab[3] = 1;
        dat_tab[1] = 12'(($urandom % 4095) + 1);
        dat_tab[3] = 12'(($urandom % 4095) + 1);
        do_scan("tmo", 8'h01, 8'h03);
        if (samp_cyc.size() >= 3) begin
            chk("tmo_rise_cycle", terr_rise, samp_cyc[1] + TC + 1);
            chk("tmo_next_sample", samp_cyc[2], samp_cyc[1] + TC + 1 + SC);
        end else begin
            chk("tmo_sample_count", samp_cyc.size(), 3);
        end
        dly_tab[2] = 1;

        // Stale strobe in SAMPLE ignored, strobe at WAIT cycle 1 captured; start clears timeout_err
        stale_en       = 1'b1;
        dly_tab[8'h40] = 1;
        dat_tab[8'h40] = 12'h123;
        clear_mon();
        model(8'h40, 8'h40);
        start_scan(8'h40, 8'h40);
        chk("start_clears_terr", bus.timeout_err, 0);
        wait_idle("stale", 60);
        tick(2);
        compare("stale");
        stale_en = 1'b0;

        // Abort while waiting on the second channel
        dly_tab[8'h10] = 2;
        dly_tab[8'h11] = 0;
        clear_mon();
        start_scan(8'h10, 8'h12);
        begin
            int k = 0;
            while (samp_cnt < 2 && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        chk("abort_reached_ch2", (samp_cnt >= 2), 1);
        tick(3);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_en", bus.an_mux_enable, 0);
        tick(TC + 10);
        chk("abort_nres", obs_addr.size(), 1);
        chk("abort_done", done_cnt, 0);
        dly_tab[8'h11] = 1;

        // start while busy does not change the range
        for (int a = 8'h20; a <= 8'h22; a++) dly_tab[a] = 1;
        clear_mon();
        model(8'h20, 8'h22);
        start_scan(8'h20, 8'h22);
        tick(3);
        bus.first_addr = 8'h50;
        bus.last_addr  = 8'h50;
        bus.start      = 1'b1;
        tick(1);
        bus.start = 1'b0;
        wait_idle("busy_start", 100);
        tick(2);
        compare("busy_start");

        // start together with abort in IDLE is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_idle", bus.busy, 0);
        tick(1);
        chk("start_abort_idle2", bus.busy, 0);

        // Randomized scans, including the 16-cycle timeout boundary
        for (int it = 0; it < 5; it++) begin
            logic [W-1:0] f, l;
            int len, r;
            f   = W'($urandom_range(0, 255));
            len = $urandom_range(1, 6);
            l   = W'((int'(f) + len - 1) % 256);
            for (int i = 0; i < len; i++) begin
                int a;
                a = (int'(f) + i) % 256;
                r = $urandom_range(0, 9);
                dly_tab[a] = (r == 0) ? 0 : (r == 1) ? $urandom_range(TC + 1, TC + 4) :
                             (r == 2) ? TC : $urandom_range(1, 6);
                dat_tab[a] = 12'($urandom);
            end
            do_scan($sformatf("rnd%0d", it), f, l);
            tick($urandom_range(1, 5));
        end

        // Full sweep of every address
        begin
            logic [W-1:0] f;
            f = W'($urandom_range(0, 255));
            for (int a = 0; a < 256; a++) begin
                dly_tab[a] = $urandom_range(1, 3);
                dat_tab[a] = 12'($urandom);
            end
            do_scan("sweep", f, f - 1'b1);
        end

        // Asynchronous reset mid-SETTLE, then a normal scan
        start_scan(8'h33, 8'h34);
        tick(1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        single_chk("post_rst");

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
